matmul_mac_seq: RTL and testbench
=================================

Name: matmul_mac_seq

Overview:
- Parametrised successor to the single-cycle square matrix multiplier.
- Computes Z = X·Y for runtime dimensions: X is M×K, Y is K×N, Z is M×N, all signed and row-major in separate BRAMs.
- Uses one MAC per cycle, streaming one X element and one Y element per clock from 1-cycle-latency BRAMs.
- Adds a wide accumulator, selectable saturation, a busy/done/err handshake and dimension validation.
- Sits between the X/Y input BRAMs and the Z output BRAM under the top-level controller.

Parameters:
- DATA_WIDTH, 32, signed element width of X, Y and Z.
- DIM_WIDTH, 4, width of each dimension port; legal dims are 1..2**DIM_WIDTH-1.
- ADDR_WIDTH, 2*DIM_WIDTH, BRAM address width.
- ACC_WIDTH, 2*DATA_WIDTH+DIM_WIDTH, signed accumulator width; must be at least 2*DATA_WIDTH.
- SATURATE, 1, Z write-back mode: 1 clamps to the signed DATA_WIDTH range, 0 truncates to the low DATA_WIDTH bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request a run; sampled only in IDLE.
- m_dim  in  DIM_WIDTH  rows of X; latched when start is accepted.
- n_dim  in  DIM_WIDTH  columns of Y; latched when start is accepted.
- k_dim  in  DIM_WIDTH  inner dimension; latched when start is accepted.
- x_addr  out  ADDR_WIDTH  X BRAM read address (registered).
- y_addr  out  ADDR_WIDTH  Y BRAM read address (registered).
- x_rd_data  in  DATA_WIDTH  X BRAM data; valid 1 cycle after x_addr.
- y_rd_data  in  DATA_WIDTH  Y BRAM data; valid 1 cycle after y_addr.
- z_we  out  1  Z write enable (registered).
- z_addr  out  ADDR_WIDTH  Z write address (registered).
- z_wdata  out  DATA_WIDTH  Z write data (registered).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  1-cycle pulse at the end of a run.
- err  out  1  1-cycle pulse coincident with done when any dim is 0.

Behaviour:
- Reset: synchronous. On rst=1 at a clock edge:
  - state goes to IDLE;
  - x_addr, y_addr, z_addr, z_wdata, accumulator and i/j/p counters go to 0;
  - z_we, busy, done, err go to 0.
- Reset mid-run aborts immediately. No z_we is asserted on or after that edge until a new start.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - start=1 in cycle 0 latches the dims.
  - If any dim is 0, go to FIN with err set.
  - Otherwise go to RUN with i=j=p=0.
  - start while busy=1 is ignored.
- RUN:
  - Issues one term per cycle with no bubbles. Term t (0-based, order: p fastest, then j, then i) presents x_addr=i*K+p and y_addr=p*N+j in cycle 1+t.
  - Data for term t arrives in cycle 2+t.
  - The accumulator loads the product in cycle 2+t when p was 0; otherwise it adds the product.
  - Products are a full signed DATA_WIDTH×DATA_WIDTH result, sign-extended to ACC_WIDTH.
  - After the address for the last term (i=M-1, j=N-1, p=K-1) is issued, go to DRAIN.
- Write-back:
  - For Z element e=i*N+j, z_we=1 in cycle 2+(e+1)*K after start acceptance.
  - z_addr=e; z_wdata is the accumulated sum, saturated or truncated per SATURATE.
  - z_we is high for exactly M*N cycles total; it is never high otherwise.
  - With K=1, z_we is high on consecutive cycles.
- DRAIN: holds until the final write has been issued, then goes to FIN.
- FIN:
  - done=1 (and err if flagged) for one cycle; busy drops the same cycle.
  - Returns to IDLE.
  - Normal run: done falls in cycle 3+M*N*K.
  - Zero-dim run: done falls in cycle 2.
- Saturation (SATURATE=1): accumulator > 2**(DATA_WIDTH-1)-1 gives the max; < -2**(DATA_WIDTH-1) gives the min.
- Accumulator overflow: cannot occur when ACC_WIDTH >= 2*DATA_WIDTH+DIM_WIDTH. Narrower ACC_WIDTH wraps silently.
- Counter wrap:
  - p wraps at K-1 and increments j.
  - j wraps at N-1 and increments i.
  - Counters never exceed the latched dims.
  - Dims on the ports may change freely after acceptance.
- x_addr/y_addr hold their last value outside RUN.
- z_addr/z_wdata may hold stale values when z_we=0.

Test Plan:
- M=N=K=1, X[0]=3, Y[0]=-4, start at cycle 0 -> z_we only in cycle 3 with z_addr=0, z_wdata=-12; done in cycle 4; err=0.
- M=2, K=3, N=2, X=[1 2 3;4 5 6], Y=[7 8;9 10;11 12] -> writes 58,64,139,154 at addr 0..3 in cycles 5,8,11,14; done in cycle 15.
- DATA_WIDTH=8, M=N=1, K=2, X=Y=[127,127] -> SATURATE=1 gives z_wdata=127; SATURATE=0 gives z_wdata=0x02 (low byte of 32258).
- k_dim=0, start -> no z_we; done=err=1 in cycle 2; busy high in cycle 1 only.
- 3×3 run with start held high throughout and dims changed mid-run -> a single run with the original dims; a second run starts only after the cycle done falls.
- rst=1 in the middle of a 4×4×4 run -> next cycle z_we=busy=done=0 and all addresses 0; a new start then produces a correct 2×2×2 identity product.

Source files
------------

// File: rtl/matmul_mac_seq.sv
// Sequential signed matrix multiplier Z = X*Y with runtime M/N/K dims.
// One MAC per clock fed from 1-cycle-latency X/Y BRAMs; results written to a Z BRAM.
module matmul_mac_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIM_WIDTH  = 4,
    parameter int unsigned ADDR_WIDTH = 2 * DIM_WIDTH,
    parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + DIM_WIDTH,
    parameter bit          SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  m_dim,
    input  logic [DIM_WIDTH-1:0]  n_dim,
    input  logic [DIM_WIDTH-1:0]  k_dim,
    output logic [ADDR_WIDTH-1:0] x_addr,
    output logic [ADDR_WIDTH-1:0] y_addr,
    input  logic [DATA_WIDTH-1:0] x_rd_data,
    input  logic [DATA_WIDTH-1:0] y_rd_data,
    output logic                  z_we,
    output logic [ADDR_WIDTH-1:0] z_addr,
    output logic [DATA_WIDTH-1:0] z_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [DIM_WIDTH-1:0]  m_q, m_d, n_q, n_d, k_q, k_d;
    logic                  zero_q, zero_d;
    logic [DIM_WIDTH-1:0]  i_q, i_d, j_q, j_d, p_q, p_d;
    logic [ADDR_WIDTH-1:0] e_q, e_d;
    logic [ADDR_WIDTH-1:0] x_addr_q, x_addr_d, y_addr_q, y_addr_d;
    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_first_q, s2_first_d;
    logic                  s2_last_q, s2_last_d;
    logic [ADDR_WIDTH-1:0] s2_e_q, s2_e_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                  z_we_q, z_we_d;
    logic [ADDR_WIDTH-1:0] z_addr_q, z_addr_d;
    logic [DATA_WIDTH-1:0] z_wdata_q, z_wdata_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic                  dims_zero_c;
    logic                  p_last_c, j_last_c, i_last_c, last_term_c;
    logic                  final_wr_c;
    logic                  addr_upd_c;
    logic signed [PROD_WIDTH-1:0] prod_c;
    logic signed [ACC_WIDTH-1:0]  prod_ext_c;
    logic signed [ACC_WIDTH-1:0]  acc_sum_c;
    logic [DATA_WIDTH-1:0]        wb_c;

    assign dims_zero_c = (m_dim == '0) || (n_dim == '0) || (k_dim == '0);
    assign p_last_c    = (p_q == k_q - DIM_WIDTH'(1));
    assign j_last_c    = (j_q == n_q - DIM_WIDTH'(1));
    assign i_last_c    = (i_q == m_q - DIM_WIDTH'(1));
    assign last_term_c = p_last_c && j_last_c && i_last_c;
    // DRAIN is entered after the last issue; the last term's write is the final one
    assign final_wr_c  = s2_valid_q && s2_last_q;

    // Full-precision signed product, sign-extended into the accumulator domain
    assign prod_c     = PROD_WIDTH'($signed(x_rd_data)) * PROD_WIDTH'($signed(y_rd_data));
    assign prod_ext_c = ACC_WIDTH'(prod_c);
    assign acc_sum_c  = s2_first_q ? prod_ext_c : (acc_q + prod_ext_c);

    always_comb begin
        wb_c = DATA_WIDTH'(acc_sum_c);
        if (SATURATE) begin
            if (acc_sum_c > SAT_MAX) begin
                wb_c = D_MAX;
            end else if (acc_sum_c < SAT_MIN) begin
                wb_c = D_MIN;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = dims_zero_c ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_term_c) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (final_wr_c) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output, counter and datapath next values
    always_comb begin
        m_d        = m_q;
        n_d        = n_q;
        k_d        = k_q;
        zero_d     = zero_q;
        i_d        = i_q;
        j_d        = j_q;
        p_d        = p_q;
        e_d        = e_q;
        x_addr_d   = x_addr_q;
        y_addr_d   = y_addr_q;
        addr_upd_c = 1'b0;
        s2_valid_d = 1'b0;
        s2_first_d = s2_first_q;
        s2_last_d  = s2_last_q;
        s2_e_d     = s2_e_q;
        acc_d      = acc_q;
        z_we_d     = 1'b0;
        z_addr_d   = z_addr_q;
        z_wdata_d  = z_wdata_q;
        busy_d     = (state_d != ST_IDLE);
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d    = m_dim;
                    n_d    = n_dim;
                    k_d    = k_dim;
                    zero_d = dims_zero_c;
                    i_d    = '0;
                    j_d    = '0;
                    p_d    = '0;
                    e_d    = '0;
                    addr_upd_c = !dims_zero_c;
                end
            end
            ST_RUN: begin
                s2_valid_d = 1'b1;
                s2_first_d = (p_q == '0);
                s2_last_d  = p_last_c;
                s2_e_d     = e_q;
                if (!last_term_c) begin
                    addr_upd_c = 1'b1;
                    if (p_last_c) begin
                        p_d = '0;
                        e_d = e_q + ADDR_WIDTH'(1);
                        if (j_last_c) begin
                            j_d = '0;
                            i_d = i_q + DIM_WIDTH'(1);
                        end else begin
                            j_d = j_q + DIM_WIDTH'(1);
                        end
                    end else begin
                        p_d = p_q + DIM_WIDTH'(1);
                    end
                end
            end
            ST_FIN: begin
                done_d = 1'b1;
                err_d  = zero_q;
            end
            default: ;
        endcase

        // Address uses the latched dims of the next issued term
        if (addr_upd_c) begin
            x_addr_d = ADDR_WIDTH'(i_d) * ADDR_WIDTH'(k_d) + ADDR_WIDTH'(p_d);
            y_addr_d = ADDR_WIDTH'(p_d) * ADDR_WIDTH'(n_d) + ADDR_WIDTH'(j_d);
        end

        // MAC stage aligned with returning BRAM data
        if (s2_valid_q) begin
            acc_d = acc_sum_c;
            if (s2_last_q) begin
                z_we_d    = 1'b1;
                z_addr_d  = s2_e_q;
                z_wdata_d = wb_c;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q        <= '0;
            n_q        <= '0;
            k_q        <= '0;
            zero_q     <= 1'b0;
            i_q        <= '0;
            j_q        <= '0;
            p_q        <= '0;
            e_q        <= '0;
            x_addr_q   <= '0;
            y_addr_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_e_q     <= '0;
            acc_q      <= '0;
            z_we_q     <= 1'b0;
            z_addr_q   <= '0;
            z_wdata_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            m_q        <= m_d;
            n_q        <= n_d;
            k_q        <= k_d;
            zero_q     <= zero_d;
            i_q        <= i_d;
            j_q        <= j_d;
            p_q        <= p_d;
            e_q        <= e_d;
            x_addr_q   <= x_addr_d;
            y_addr_q   <= y_addr_d;
            s2_valid_q <= s2_valid_d;
            s2_first_q <= s2_first_d;
            s2_last_q  <= s2_last_d;
            s2_e_q     <= s2_e_d;
            acc_q      <= acc_d;
            z_we_q     <= z_we_d;
            z_addr_q   <= z_addr_d;
            z_wdata_q  <= z_wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign x_addr  = x_addr_q;
    assign y_addr  = y_addr_q;
    assign z_we    = z_we_q;
    assign z_addr  = z_addr_q;
    assign z_wdata = z_wdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_matmul_mac_seq.sv
// Directed bench for matmul_mac_seq: 32-bit main instance plus two 8-bit
// instances (saturating and truncating) sharing one 1x2 * 2x1 stimulus.
module tb_matmul_mac_seq;

    localparam int unsigned DW  = 32;
    localparam int unsigned DIM = 4;
    localparam int unsigned AW  = 8;
    localparam int unsigned DW8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, start8;
    logic [DIM-1:0] m_dim, n_dim, k_dim;

    logic [AW-1:0]  x_addr, y_addr, z_addr;
    logic [DW-1:0]  x_rd, y_rd, z_wdata;
    logic           z_we, busy, done, err;

    logic [AW-1:0]  s_x_addr, s_y_addr, s_z_addr, t_x_addr, t_y_addr, t_z_addr;
    logic [DW8-1:0] s_x_rd, s_y_rd, s_z_wdata, t_x_rd, t_y_rd, t_z_wdata;
    logic           s_z_we, s_busy, s_done, s_err, t_z_we, t_busy, t_done, t_err;

    logic [DW-1:0]  xmem [256];
    logic [DW-1:0]  ymem [256];
    logic [DW8-1:0] x8mem [256];
    logic [DW8-1:0] y8mem [256];

    always_ff @(posedge clk) begin
        x_rd   <= xmem[x_addr];
        y_rd   <= ymem[y_addr];
        s_x_rd <= x8mem[s_x_addr];
        s_y_rd <= y8mem[s_y_addr];
        t_x_rd <= x8mem[t_x_addr];
        t_y_rd <= y8mem[t_y_addr];
    end

    matmul_mac_seq #(.DATA_WIDTH(DW), .DIM_WIDTH(DIM)) dut (
        .clk(clk), .rst(rst), .start(start),
        .m_dim(m_dim), .n_dim(n_dim), .k_dim(k_dim),
        .x_addr(x_addr), .y_addr(y_addr), .x_rd_data(x_rd), .y_rd_data(y_rd),
        .z_we(z_we), .z_addr(z_addr), .z_wdata(z_wdata),
        .busy(busy), .done(done), .err(err)
    );

    matmul_mac_seq #(.DATA_WIDTH(DW8), .DIM_WIDTH(DIM), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .start(start8),
        .m_dim(m_dim), .n_dim(n_dim), .k_dim(k_dim),
        .x_addr(s_x_addr), .y_addr(s_y_addr), .x_rd_data(s_x_rd), .y_rd_data(s_y_rd),
        .z_we(s_z_we), .z_addr(s_z_addr), .z_wdata(s_z_wdata),
        .busy(s_busy), .done(s_done), .err(s_err)
    );

    matmul_mac_seq #(.DATA_WIDTH(DW8), .DIM_WIDTH(DIM), .SATURATE(1'b0)) dut_trunc (
        .clk(clk), .rst(rst), .start(start8),
        .m_dim(m_dim), .n_dim(n_dim), .k_dim(k_dim),
        .x_addr(t_x_addr), .y_addr(t_y_addr), .x_rd_data(t_x_rd), .y_rd_data(t_y_rd),
        .z_we(t_z_we), .z_addr(t_z_addr), .z_wdata(t_z_wdata),
        .busy(t_busy), .done(t_done), .err(t_err)
    );

    int n_checks = 0;
    int n_errs   = 0;

    int            wc[$];
    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];
    int            exp_q[$];

    int   dcyc;
    logic derr;
    int   we_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 into cycle 0; returns #1 into cycle 1
    task automatic go(input int m, input int n, input int k, input bit hold);
        start = 1'b1;
        m_dim = DIM'(m);
        n_dim = DIM'(n);
        k_dim = DIM'(k);
        step();
        if (!hold) start = 1'b0;
    endtask

    // Entered #1 into cycle 1; returns in the done cycle (or after the bound)
    task automatic collect(input int maxc, output int dc, output logic de);
        dc = -1;
        de = 1'b0;
        wc.delete();
        wa.delete();
        wd.delete();
        for (int c = 1; c <= maxc; c++) begin
            if (z_we) begin
                wc.push_back(c);
                wa.push_back(z_addr);
                wd.push_back(z_wdata);
            end
            if (done) begin
                dc = c;
                de = err;
                break;
            end
            step();
        end
    endtask

    task automatic check_run(input string tag, input int k, input int exp_done,
                             input int dc, input logic de);
        chk({tag, ".done_cyc"}, 32'(dc), 32'(exp_done));
        chk({tag, ".err"}, 32'(de), 32'd0);
        chk({tag, ".n_writes"}, 32'(wc.size()), 32'(exp_q.size()));
        for (int e = 0; e < exp_q.size() && e < wc.size(); e++) begin
            chk($sformatf("%s.wr%0d.cyc", tag, e), 32'(wc[e]), 32'(2 + (e + 1) * k));
            chk($sformatf("%s.wr%0d.addr", tag, e), 32'(wa[e]), 32'(e));
            chk($sformatf("%s.wr%0d.data", tag, e), wd[e], 32'(exp_q[e]));
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start8 = 1'b0;
        m_dim  = '0;
        n_dim  = '0;
        k_dim  = '0;
        for (int a = 0; a < 256; a++) begin
            xmem[a]  = '0;
            ymem[a]  = '0;
            x8mem[a] = '0;
            y8mem[a] = '0;
        end
        step();
        step();
        chk("rst.z_we", 32'(z_we), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.x_addr", 32'(x_addr), 32'd0);
        chk("rst.y_addr", 32'(y_addr), 32'd0);
        chk("rst.z_addr", 32'(z_addr), 32'd0);
        rst = 1'b0;
        step();

        // 1x1x1: 3 * -4
        xmem[0] = 32'd3;
        ymem[0] = 32'(-4);
        go(1, 1, 1, 1'b0);
        chk("t1.busy_c1", 32'(busy), 32'd1);
        collect(40, dcyc, derr);
        exp_q = '{-12};
        check_run("t1", 1, 4, dcyc, derr);
        chk("t1.busy_at_done", 32'(busy), 32'd0);
        step();

        // 2x3 * 3x2
        for (int a = 0; a < 6; a++) begin
            xmem[a] = 32'(a + 1);
            ymem[a] = 32'(a + 7);
        end
        go(2, 2, 3, 1'b0);
        collect(60, dcyc, derr);
        exp_q = '{58, 64, 139, 154};
        check_run("t2", 3, 15, dcyc, derr);
        step();

        // k=0: error path, no writes
        go(2, 2, 0, 1'b0);
        chk("zero.busy_c1", 32'(busy), 32'd1);
        chk("zero.done_c1", 32'(done), 32'd0);
        step();
        chk("zero.done_c2", 32'(done), 32'd1);
        chk("zero.err_c2", 32'(err), 32'd1);
        chk("zero.busy_c2", 32'(busy), 32'd0);
        chk("zero.z_we_c2", 32'(z_we), 32'd0);
        step();
        chk("zero.done_c3", 32'(done), 32'd0);
        chk("zero.err_c3", 32'(err), 32'd0);
        step();

        // 3x3x3 with start held and dims changed after acceptance; Y = 2*I
        for (int a = 0; a < 9; a++) begin
            xmem[a] = 32'(a + 1);
            ymem[a] = ((a % 4) == 0) ? 32'd2 : 32'd0;
        end
        go(3, 3, 3, 1'b1);
        m_dim = 4'd1;
        n_dim = 4'd1;
        k_dim = 4'd1;
        collect(100, dcyc, derr);
        exp_q = '{2, 4, 6, 8, 10, 12, 14, 16, 18};
        check_run("t3", 3, 30, dcyc, derr);
        chk("t3.busy_at_done", 32'(busy), 32'd0);
        step();
        start = 1'b0;
        chk("t3.second_busy", 32'(busy), 32'd1);
        collect(40, dcyc, derr);
        exp_q = '{2};
        check_run("t3b", 1, 4, dcyc, derr);
        step();

        // Reset in the middle of a 4x4x4 run
        for (int a = 0; a < 16; a++) begin
            xmem[a] = 32'(a + 1);
            ymem[a] = 32'(16 - a);
        end
        go(4, 4, 4, 1'b0);
        repeat (20) step();
        rst = 1'b1;
        step();
        chk("rstmid.z_we", 32'(z_we), 32'd0);
        chk("rstmid.busy", 32'(busy), 32'd0);
        chk("rstmid.done", 32'(done), 32'd0);
        chk("rstmid.x_addr", 32'(x_addr), 32'd0);
        chk("rstmid.y_addr", 32'(y_addr), 32'd0);
        chk("rstmid.z_addr", 32'(z_addr), 32'd0);
        rst = 1'b0;
        we_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (z_we || busy || done) we_cnt++;
            step();
        end
        chk("rstmid.quiet", 32'(we_cnt), 32'd0);

        // 2x2x2: identity * Y
        xmem[0] = 32'd1;
        xmem[1] = 32'd0;
        xmem[2] = 32'd0;
        xmem[3] = 32'd1;
        ymem[0] = 32'd5;
        ymem[1] = 32'(-6);
        ymem[2] = 32'd7;
        ymem[3] = 32'd8;
        go(2, 2, 2, 1'b0);
        collect(40, dcyc, derr);
        exp_q = '{5, -6, 7, 8};
        check_run("ident", 2, 11, dcyc, derr);
        step();

        // 8-bit: 127*127 + 127*127 = 32258 -> sat 127, trunc 0x02
        x8mem[0] = 8'd127;
        x8mem[1] = 8'd127;
        y8mem[0] = 8'd127;
        y8mem[1] = 8'd127;
        start8 = 1'b1;
        m_dim  = 4'd1;
        n_dim  = 4'd1;
        k_dim  = 4'd2;
        step();
        start8 = 1'b0;
        begin
            int s_cnt, t_cnt, s_wcyc, s_dcyc;
            logic [DW8-1:0] s_val, t_val;
            s_cnt = 0; t_cnt = 0; s_wcyc = -1; s_dcyc = -1;
            s_val = '0; t_val = '0;
            for (int c = 1; c <= 12; c++) begin
                if (s_z_we) begin s_cnt++; s_val = s_z_wdata; s_wcyc = c; end
                if (t_z_we) begin t_cnt++; t_val = t_z_wdata; end
                if (s_done && s_dcyc < 0) s_dcyc = c;
                step();
            end
            chk("w8.sat_n", 32'(s_cnt), 32'd1);
            chk("w8.trunc_n", 32'(t_cnt), 32'd1);
            chk("w8.sat_data", 32'(s_val), 32'd127);
            chk("w8.trunc_data", 32'(t_val), 32'h02);
            chk("w8.wr_cyc", 32'(s_wcyc), 32'd4);
            chk("w8.done_cyc", 32'(s_dcyc), 32'd5);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
